jelly_pattern_generator_ctl: RTL and testbench

Run controller for the AXI4-Stream test-pattern generator. It sequences the generator's `enable`/`busy` handshake to produce one-shot bursts of N frames or continuous output, with clean stop at a frame boundary. It also passively monitors the generator's output stream to count completed frames and flag framing errors. It sits between the register block (control/status) and the generator plus its downstream sink.

---
 rtl/jelly_pattern_generator_ctl.sv | 160 ++++++++++++++++
 tb/tb_jelly_pattern_generator_ctl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jelly_pattern_generator_ctl.sv
// Run controller for the AXI4-Stream test-pattern generator: sequences the
// generator enable/busy handshake and passively monitors its output stream.
module jelly_pattern_generator_ctl #(
    parameter int X_NUM       = 640,
    parameter int Y_NUM       = 480,
    parameter int X_WIDTH     = 12,
    parameter int Y_WIDTH     = 12,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                   aresetn,
    input  logic                   aclk,

    input  logic                   ctl_start,
    input  logic                   ctl_stop,
    input  logic                   ctl_continuous,
    input  logic [FRAME_WIDTH-1:0] ctl_frame_num,

    output logic                   gen_enable,
    input  logic                   gen_busy,

    input  logic                   mon_tuser,
    input  logic                   mon_tlast,
    input  logic                   mon_tvalid,
    input  logic                   mon_tready,

    output logic                   status_busy,
    output logic [FRAME_WIDTH-1:0] status_frame_count,
    output logic                   status_error,
    output logic                   irq_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_NUM - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_NUM - 1);

    // Monitor position just after the first pixel of a frame.
    localparam logic [X_WIDTH-1:0] X_RESYNC = (X_NUM == 1) ? X_WIDTH'(0) : X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_RESYNC = (X_NUM == 1 && Y_NUM > 1) ? Y_WIDTH'(1) : Y_WIDTH'(0);

    state_t                 state;
    state_t                 state_next;
    logic                   accept_start;
    logic                   irq_next;

    logic [X_WIDTH-1:0]     x;
    logic [Y_WIDTH-1:0]     y;
    logic [FRAME_WIDTH-1:0] target;

    logic                   hs;
    logic                   frame_start;
    logic                   frame_end;
    logic                   x_at_last;
    logic                   y_at_last;
    logic                   at_origin;
    logic                   pixel_error;
    logic                   last_frame_due;

    assign hs          = mon_tvalid & mon_tready;
    assign x_at_last   = (x == X_LAST);
    assign y_at_last   = (y == Y_LAST);
    assign at_origin   = (x == '0) && (y == '0);
    assign frame_start = hs & mon_tuser;
    assign frame_end   = hs & mon_tlast & y_at_last;
    assign pixel_error = hs & ((mon_tuser != at_origin) | (mon_tlast != x_at_last));

    // One extra bit so the saturated all-ones count cannot wrap the comparison.
    assign last_frame_due = ({1'b0, status_frame_count} + (FRAME_WIDTH+1)'(1))
                            >= {1'b0, target};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        irq_next     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctl_start) begin
                    state_next   = ST_RUN;
                    accept_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (ctl_stop) begin
                    state_next = ST_STOP;
                end else if (!ctl_continuous && frame_start && last_frame_due) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (frame_end && !gen_busy) begin
                    state_next = ST_IDLE;
                    irq_next   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            gen_enable  <= 1'b0;
            status_busy <= 1'b0;
            irq_done    <= 1'b0;
        end else begin
            state       <= state_next;
            gen_enable  <= (state_next == ST_RUN);
            status_busy <= (state_next != ST_IDLE);
            irq_done    <= irq_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x <= '0;
            y <= '0;
        end else if (accept_start) begin
            x <= '0;
            y <= '0;
        end else if (hs) begin
            if (frame_start) begin
                x <= X_RESYNC;
                y <= Y_RESYNC;
            end else if (x_at_last) begin
                x <= '0;
                y <= y_at_last ? '0 : y + Y_WIDTH'(1);
            end else begin
                x <= x + X_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            status_frame_count <= '0;
            status_error       <= 1'b0;
            target             <= FRAME_WIDTH'(1);
        end else if (accept_start) begin
            status_frame_count <= '0;
            status_error       <= 1'b0;
            target             <= (ctl_frame_num == '0) ? FRAME_WIDTH'(1) : ctl_frame_num;
        end else begin
            if (state != ST_IDLE && frame_end && status_frame_count != '1) begin
                status_frame_count <= status_frame_count + FRAME_WIDTH'(1);
            end
            if (pixel_error) begin
                status_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jelly_pattern_generator_ctl.sv
// Self-checking bench: a small generator model drives the stream taps and a
// beat-index reference model predicts every registered output each cycle.
module tb_jelly_pattern_generator_ctl;

    localparam int X_NUM  = 4;
    localparam int Y_NUM  = 3;
    localparam int FW     = 16;
    localparam int NPIX   = X_NUM * Y_NUM;
    localparam int FMAX   = (1 << FW) - 1;

    logic          aresetn;
    logic          aclk;
    logic          ctl_start;
    logic          ctl_stop;
    logic          ctl_continuous;
    logic [FW-1:0] ctl_frame_num;
    logic          gen_enable;
    logic          gen_busy;
    logic          mon_tuser;
    logic          mon_tlast;
    logic          mon_tvalid;
    logic          mon_tready;
    logic          status_busy;
    logic [FW-1:0] status_frame_count;
    logic          status_error;
    logic          irq_done;

    int checks   = 0;
    int failures = 0;

    jelly_pattern_generator_ctl #(
        .X_NUM(X_NUM), .Y_NUM(Y_NUM), .X_WIDTH(12), .Y_WIDTH(12), .FRAME_WIDTH(FW)
    ) dut (
        .aresetn(aresetn), .aclk(aclk),
        .ctl_start(ctl_start), .ctl_stop(ctl_stop),
        .ctl_continuous(ctl_continuous), .ctl_frame_num(ctl_frame_num),
        .gen_enable(gen_enable), .gen_busy(gen_busy),
        .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
        .status_busy(status_busy), .status_frame_count(status_frame_count),
        .status_error(status_error), .irq_done(irq_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Generator stand-in: latches enable to begin, re-samples it on the last pixel.
    logic g_active;
    int   g_idx;
    logic inj;
    logic inj_armed;
    logic rand_ready;

    assign mon_tvalid = g_active;
    assign mon_tuser  = (g_active && g_idx == 0) || inj;
    assign mon_tlast  = g_active && (g_idx % X_NUM == X_NUM - 1);
    assign gen_busy   = g_active && !(g_idx == NPIX - 1 && !gen_enable);

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            g_active <= 1'b0;
            g_idx    <= 0;
        end else if (!g_active) begin
            if (gen_enable) begin
                g_active <= 1'b1;
                g_idx    <= 0;
            end
        end else if (mon_tvalid && mon_tready) begin
            if (g_idx == NPIX - 1) begin
                if (gen_enable) g_idx <= 0;
                else            g_active <= 1'b0;
            end else begin
                g_idx <= g_idx + 1;
            end
        end
    end

    // Reference model: monitor position kept as a linear beat index in the frame.
    int   m_phase;   // 0 idle, 1 running, 2 stopping
    int   m_count;
    int   m_target;
    int   m_pos;
    logic m_err;
    logic m_irq;
    logic m_hs, m_fs, m_fe, m_perr;

    assign m_hs   = mon_tvalid && mon_tready;
    assign m_fs   = m_hs && mon_tuser;
    assign m_fe   = m_hs && mon_tlast && (m_pos / X_NUM == Y_NUM - 1);
    assign m_perr = m_hs && ((mon_tuser != (m_pos == 0)) ||
                             (mon_tlast != (m_pos % X_NUM == X_NUM - 1)));

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_phase <= 0; m_count <= 0; m_target <= 1; m_pos <= 0;
            m_err   <= 1'b0; m_irq <= 1'b0;
        end else begin
            m_irq <= 1'b0;
            if (m_phase == 0 && ctl_start) begin
                m_phase  <= 1;
                m_count  <= 0;
                m_err    <= 1'b0;
                m_pos    <= 0;
                m_target <= (ctl_frame_num == 0) ? 1 : int'(ctl_frame_num);
            end else begin
                if (m_hs) m_pos <= m_fs ? (1 % NPIX) : (m_pos + 1) % NPIX;
                if (m_perr) m_err <= 1'b1;
                if (m_phase != 0 && m_fe && m_count < FMAX) m_count <= m_count + 1;
                if (m_phase == 1) begin
                    if (ctl_stop || (!ctl_continuous && m_fs && m_count + 1 >= m_target))
                        m_phase <= 2;
                end else if (m_phase == 2 && m_fe && !gen_busy) begin
                    m_phase <= 0;
                    m_irq   <= 1'b1;
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            check("gen_enable",   int'(gen_enable),         int'(m_phase == 1));
            check("status_busy",  int'(status_busy),        int'(m_phase != 0));
            check("frame_count",  int'(status_frame_count), m_count);
            check("status_error", int'(status_error),       int'(m_err));
            check("irq_done",     int'(irq_done),           int'(m_irq));
        end
    end

    // Event recorders keyed to the handshake count.
    int   hs_total;
    int   irq_total;
    int   irq_hs;
    int   en_fall_hs;
    logic prev_en;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) hs_total <= 0;
        else if (m_hs) hs_total <= hs_total + 1;
    end

    always @(negedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            irq_total <= 0; irq_hs <= -1; en_fall_hs <= -1; prev_en <= 1'b0;
        end else begin
            prev_en <= gen_enable;
            if (prev_en && !gen_enable) en_fall_hs <= hs_total;
            if (irq_done) begin
                irq_total <= irq_total + 1;
                irq_hs    <= hs_total;
            end
        end
    end

    task automatic tick();
        @(negedge aclk);
        ctl_start  = 1'b0;
        ctl_stop   = 1'b0;
        inj        = 1'b0;
        mon_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (inj_armed && g_active && g_idx == 2) begin
            mon_tready = 1'b1;
            inj        = 1'b1;
            inj_armed  = 1'b0;
        end
    endtask

    // stop_at > 0: issue ctl_stop so it is sampled together with that beat.
    task automatic do_run(input string tag, input bit cont, input int fnum, input bit rnd,
                          input int stop_at, input int exp_hs, input int exp_fall,
                          input int exp_count, input bit exp_err);
        int  base_hs;
        int  base_irq;
        bit  done;
        bit  stopped;
        bit  err_pending;
        base_hs    = hs_total;
        base_irq   = irq_total;
        rand_ready = rnd;
        done       = 1'b0;
        stopped    = 1'b0;
        err_pending = 1'b0;
        tick();
        ctl_start      = 1'b1;
        ctl_continuous = cont;
        ctl_frame_num  = FW'(fnum);
        tick();
        check({tag, "_err_cleared"}, int'(status_error), 0);
        check({tag, "_busy_set"}, int'(status_busy), 1);
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            if (err_pending) begin
                check({tag, "_err_next_cycle"}, int'(status_error), 1);
                err_pending = 1'b0;
            end
            if (inj) err_pending = 1'b1;
            if (stop_at > 0 && !stopped && hs_total - base_hs >= stop_at - 1) begin
                ctl_stop    = 1'b1;
                mon_tready  = 1'b1;
                stopped     = 1'b1;
            end
            if (irq_done) done = 1'b1;
        end
        check({tag, "_completed"}, int'(done), 1);
        rand_ready = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check({tag, "_hs_total"},   hs_total - base_hs,   exp_hs);
        check({tag, "_enable_fall"}, en_fall_hs - base_hs, exp_fall);
        check({tag, "_irq_beat"},   irq_hs - base_hs,     exp_hs);
        check({tag, "_irq_pulses"}, irq_total - base_irq, 1);
        check({tag, "_count"},      int'(status_frame_count), exp_count);
        check({tag, "_error"},      int'(status_error),   int'(exp_err));
        check({tag, "_idle"},       int'(status_busy),    0);
    endtask

    initial begin
        aresetn        = 1'b0;
        ctl_start      = 1'b0;
        ctl_stop       = 1'b0;
        ctl_continuous = 1'b0;
        ctl_frame_num  = '0;
        mon_tready     = 1'b1;
        inj            = 1'b0;
        inj_armed      = 1'b0;
        rand_ready     = 1'b0;
        #23;
        check("reset_enable", int'(gen_enable), 0);
        check("reset_busy",   int'(status_busy), 0);
        check("reset_count",  int'(status_frame_count), 0);
        check("reset_irq",    int'(irq_done), 0);
        aresetn = 1'b1;
        tick();
        // A lone stop in idle does nothing.
        ctl_stop = 1'b1;
        tick(); tick();
        check("idle_stop_ignored", int'(status_busy), 0);

        do_run("oneshot2",   1'b0, 2, 1'b0, 0,  24, 13, 2, 1'b0);
        do_run("frames0",    1'b0, 0, 1'b0, 0,  12, 1,  1, 1'b0);
        do_run("cont_stop",  1'b1, 5, 1'b0, 30, 36, 30, 3, 1'b0);
        do_run("rand_ready", 1'b0, 3, 1'b1, 0,  36, 25, 3, 1'b0);
        inj_armed = 1'b1;
        do_run("inject",     1'b0, 1, 1'b0, 0,  12, 1,  1, 1'b1);
        do_run("after_inj",  1'b0, 1, 1'b0, 0,  12, 1,  1, 1'b0);

        // Asynchronous reset in the middle of the first frame.
        tick();
        ctl_start      = 1'b1;
        ctl_continuous = 1'b1;
        ctl_frame_num  = FW'(4);
        for (int i = 0; i < 200 && hs_total < 5; i++) tick();
        #2 aresetn = 1'b0;
        #1;
        check("async_enable", int'(gen_enable), 0);
        check("async_busy",   int'(status_busy), 0);
        check("async_count",  int'(status_frame_count), 0);
        check("async_error",  int'(status_error), 0);
        check("async_irq",    int'(irq_done), 0);
        tick(); tick();
        aresetn = 1'b1;
        ctl_continuous = 1'b0;
        tick();
        do_run("post_reset", 1'b0, 1, 1'b0, 0, 12, 1, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
